// File: rtl/duoseg_pkg.sv
// Shared types and constants for the duo-segment display sequencer:
// FSM states, control register map, CTRL bit positions, the segment
// table and the decimal counting helper.
package duoseg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WR_L,
      WR_R
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_VALUE  = 2'd1;
   localparam logic [1:0] REG_PERIOD = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_DOWN = 1;
   localparam int CTRL_BCD  = 2;

   // Lit-segment patterns g..a for digits 0..F; element 0 is the last entry.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // One decimal count step over four BCD digits. Digits above 9 are
   // clamped to 9 first so a corrupted value still counts sensibly.
   function automatic logic [15:0] bcdStep(input logic [15:0] value, input logic down);
      logic [3:0]  digit;
      logic        carry;
      logic [15:0] result;
      carry  = 1'b1;
      result = '0;
      for (int i = 0; i < 4; i++) begin
         digit = value[4*i +: 4];
         if (digit > 4'd9) digit = 4'd9;
         if (carry) begin
            if (down) begin
               if (digit == 4'd0) digit = 4'd9;
               else begin
                  digit = digit - 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (digit == 4'd9) digit = 4'd0;
               else begin
                  digit = digit + 4'd1;
                  carry = 1'b0;
               end
            end
         end
         result[4*i +: 4] = digit;
      end
      return result;
   endfunction

endpackage

// File: rtl/duoseg_seq_ctrl_if.sv
// Write-only Avalon-MM link between the sequencer and one duo-segment
// display slave.
interface duoseg_seq_ctrl_if;
   logic [1:0]  address;
   logic        write;
   logic [15:0] writedata;
   logic [1:0]  byteenable;
   logic        waitrequest;

   modport master (
      output address, write, writedata, byteenable,
      input  waitrequest
   );

   modport slave (
      input  address, write, writedata, byteenable,
      output waitrequest
   );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to seven-segment pattern (g..a) with a blanking input and
// optional inversion for common-anode displays.
module seg7_decode
   import duoseg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);
   logic [6:0] litPattern;

   // Look up the lit segments, then flip polarity for active-low panels.
   always_comb begin
      litPattern = blank_i ? 7'h00 : SEG_TABLE[nibble_i];
      seg_o      = ACTIVE_LOW ? ~litPattern : litPattern;
   end
endmodule

// File: rtl/duoseg_seq_ctrl.sv
// Display sequencer: CPU register block, millisecond timebase with a
// hex/BCD counter, and an FSM that pushes every value change to the
// left and right duo-segment slaves as two back-to-back writes.
module duoseg_seq_ctrl
   import duoseg_pkg::*;
#(
   parameter int         TICK_DIV       = 50000,
   parameter logic [1:0] DISP_ADDR      = 2'd0,
   parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        csi_clk,
   input  logic        csi_reset_n,
   input  logic [1:0]  avs_s1_address,
   input  logic        avs_s1_read,
   input  logic        avs_s1_write,
   input  logic [15:0] avs_s1_writedata,
   input  logic [1:0]  avs_s1_byteenable,
   output logic [15:0] avs_s1_readdata,
   duoseg_seq_ctrl_if.master avm_l,
   duoseg_seq_ctrl_if.master avm_r
);
   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   state_t         state_q, state_d;
   logic [2:0]     ctrl_q, ctrl_d;
   logic [15:0]    value_q, value_d;
   logic [15:0]    period_q, period_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [15:0]    periodCnt_q, periodCnt_d;
   logic           dirty_q, dirty_d;
   logic [15:0]    readdata_q, readdata_d;
   logic [15:0]    snap_q, snap_d;
   logic           snapBcd_q, snapBcd_d;
   logic [15:0]    lData_q, lData_d;
   logic [15:0]    rData_q, rData_d;

   logic        ctrlWr, valueWr, periodWr;
   logic        tick, step, dirtyClr;
   logic [15:0] periodLast, stepValue;
   logic [6:0]  segs [4];

   // Register writes, readback, timebase and the count step.
   always_comb begin
      ctrlWr     = avs_s1_write && (avs_s1_address == REG_CTRL);
      valueWr    = avs_s1_write && (avs_s1_address == REG_VALUE);
      periodWr   = avs_s1_write && (avs_s1_address == REG_PERIOD);
      tick       = ctrl_q[CTRL_RUN] && (presc_q == TICK_LAST);
      periodLast = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;
      step       = tick && (periodCnt_q >= periodLast);

      if (ctrl_q[CTRL_BCD])       stepValue = bcdStep(value_q, ctrl_q[CTRL_DOWN]);
      else if (ctrl_q[CTRL_DOWN]) stepValue = value_q - 16'd1;
      else                        stepValue = value_q + 16'd1;

      ctrl_d = ctrl_q;
      if (ctrlWr && avs_s1_byteenable[0]) ctrl_d = avs_s1_writedata[2:0];

      value_d = value_q;
      if (valueWr) begin
         if (avs_s1_byteenable[0]) value_d[7:0]  = avs_s1_writedata[7:0];
         if (avs_s1_byteenable[1]) value_d[15:8] = avs_s1_writedata[15:8];
      end else if (step) begin
         value_d = stepValue;
      end

      period_d = period_q;
      if (periodWr) begin
         if (avs_s1_byteenable[0]) period_d[7:0]  = avs_s1_writedata[7:0];
         if (avs_s1_byteenable[1]) period_d[15:8] = avs_s1_writedata[15:8];
      end

      if (!ctrl_q[CTRL_RUN]) begin
         presc_d     = '0;
         periodCnt_d = '0;
      end else if (tick) begin
         presc_d     = '0;
         periodCnt_d = step ? 16'd0 : periodCnt_q + 16'd1;
      end else begin
         presc_d     = presc_q + PW'(1);
         periodCnt_d = periodCnt_q;
      end

      readdata_d = readdata_q;
      if (avs_s1_read) begin
         case (avs_s1_address)
            REG_CTRL:   readdata_d = {13'd0, ctrl_q};
            REG_VALUE:  readdata_d = value_q;
            REG_PERIOD: readdata_d = period_q;
            default:    readdata_d = {14'd0, dirty_q, (state_q != IDLE)};
         endcase
      end
   end

   // Four nibble decoders work from the snapshot taken when leaving IDLE.
   for (genvar i = 0; i < 4; i++) begin : g_seg
      seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
         .nibble_i (snap_q[4*i +: 4]),
         .blank_i  (snapBcd_q && (snap_q[4*i +: 4] > 4'd9)),
         .seg_o    (segs[i])
      );
   end

   // Transaction sequencing; a dirty set in the clearing cycle survives.
   always_comb begin
      state_d   = state_q;
      dirtyClr  = 1'b0;
      snap_d    = snap_q;
      snapBcd_d = snapBcd_q;
      lData_d   = lData_q;
      rData_d   = rData_q;
      case (state_q)
         IDLE: if (dirty_q) begin
            state_d   = LOAD;
            dirtyClr  = 1'b1;
            snap_d    = value_q;
            snapBcd_d = ctrl_q[CTRL_BCD];
         end
         LOAD: begin
            state_d = WR_L;
            lData_d = {1'b0, segs[3], 1'b0, segs[2]};
            rData_d = {1'b0, segs[1], 1'b0, segs[0]};
         end
         WR_L: if (!avm_l.waitrequest) state_d = WR_R;
         WR_R: if (!avm_r.waitrequest) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      dirty_d = (dirty_q && !dirtyClr) || valueWr || step || ctrlWr;
   end

   // State and register update; reset leaves dirty set so a blank push follows.
   always_ff @(posedge csi_clk) begin
      if (!csi_reset_n) begin
         state_q     <= IDLE;
         ctrl_q      <= '0;
         value_q     <= '0;
         period_q    <= '0;
         presc_q     <= '0;
         periodCnt_q <= '0;
         dirty_q     <= 1'b1;
         readdata_q  <= '0;
         snap_q      <= '0;
         snapBcd_q   <= 1'b0;
         lData_q     <= '0;
         rData_q     <= '0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         value_q     <= value_d;
         period_q    <= period_d;
         presc_q     <= presc_d;
         periodCnt_q <= periodCnt_d;
         dirty_q     <= dirty_d;
         readdata_q  <= readdata_d;
         snap_q      <= snap_d;
         snapBcd_q   <= snapBcd_d;
         lData_q     <= lData_d;
         rData_q     <= rData_d;
      end
   end

   assign avs_s1_readdata  = readdata_q;
   assign avm_l.address    = DISP_ADDR;
   assign avm_l.byteenable = 2'b11;
   assign avm_l.write      = (state_q == WR_L);
   assign avm_l.writedata  = lData_q;
   assign avm_r.address    = DISP_ADDR;
   assign avm_r.byteenable = 2'b11;
   assign avm_r.write      = (state_q == WR_R);
   assign avm_r.writedata  = rData_q;
endmodule

// File: tb/tb_duoseg_seq_ctrl.sv
// Randomised scoreboard bench for the duo-segment display sequencer.
module tb_duoseg_seq_ctrl;
   localparam int TICK_DIV = 4;
   localparam logic [6:0] SEGTAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk;
   logic        resetN;
   logic [1:0]  s1Address;
   logic        s1Read, s1Write;
   logic [15:0] s1Writedata;
   logic [1:0]  s1Byteenable;
   logic [15:0] s1Readdata;

   duoseg_seq_ctrl_if ifL ();
   duoseg_seq_ctrl_if ifR ();

   duoseg_seq_ctrl #(.TICK_DIV(TICK_DIV), .DISP_ADDR(2'd0), .SEG_ACTIVE_LOW(1'b1)) dut (
      .csi_clk           (clk),
      .csi_reset_n       (resetN),
      .avs_s1_address    (s1Address),
      .avs_s1_read       (s1Read),
      .avs_s1_write      (s1Write),
      .avs_s1_writedata  (s1Writedata),
      .avs_s1_byteenable (s1Byteenable),
      .avs_s1_readdata   (s1Readdata),
      .avm_l             (ifL),
      .avm_r             (ifR)
   );

   int          checks = 0;
   int          failures = 0;
   logic [16:0] expQ [$];
   logic [15:0] mValue;
   logic [2:0]  mCtrl;
   logic [15:0] mPeriod;
   int          stallL, stallR;
   int          cntL, cntR, targetL, targetR;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [6:0] segOf(input logic [3:0] n, input bit bcd);
      if (bcd && n > 4'd9) return 7'h7F;
      return ~SEGTAB[n];
   endfunction

   function automatic logic [15:0] modelStep(input logic [15:0] v, input bit down, input bit bcd);
      int n;
      int d;
      logic [15:0] r;
      if (!bcd) return down ? v - 16'd1 : v + 16'd1;
      n = 0;
      for (int i = 3; i >= 0; i--) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         n = n * 10 + d;
      end
      n = down ? (n + 9999) % 10000 : (n + 1) % 10000;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   task automatic pushTxn(input logic [15:0] v, input bit bcd);
      expQ.push_back({1'b0, 1'b0, segOf(v[15:12], bcd), 1'b0, segOf(v[11:8], bcd)});
      expQ.push_back({1'b1, 1'b0, segOf(v[7:4], bcd), 1'b0, segOf(v[3:0], bcd)});
   endtask

   // Monitor: every cycle a write is presented, compare against the queue head.
   task automatic checkSide(input bit side);
      logic [15:0] data;
      logic [16:0] front;
      data = side ? ifR.writedata : ifL.writedata;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL unexpected_write side=%0d actual=0x%0h required=no write", side, data);
      end else begin
         front = expQ[0];
         checkOutput(side ? "r_order" : "l_order", 32'(side), 32'(front[16]));
         checkOutput(side ? "r_data" : "l_data", 32'(data), 32'(front[15:0]));
         checkOutput(side ? "r_addr" : "l_addr", 32'(side ? ifR.address : ifL.address), 32'd0);
         checkOutput(side ? "r_be" : "l_be", 32'(side ? ifR.byteenable : ifL.byteenable), 32'd3);
         if (!(side ? ifR.waitrequest : ifL.waitrequest)) void'(expQ.pop_front());
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (resetN === 1'b1) begin
            if (ifL.write || ifR.write)
               checkOutput("lr_exclusive", 32'(ifL.write && ifR.write), 32'd0);
            if (ifL.write) checkSide(1'b0);
            if (ifR.write) checkSide(1'b1);
         end
      end
   end

   // Left slave model: stall each write for a configured or random count.
   initial begin : slaveL
      ifL.waitrequest = 1'b0;
      cntL = 0;
      targetL = 0;
      forever begin
         @(posedge clk); #1;
         if (ifL.write) begin
            if (cntL < targetL) begin ifL.waitrequest = 1'b1; cntL++; end
            else ifL.waitrequest = 1'b0;
         end else begin
            ifL.waitrequest = 1'b0;
            cntL = 0;
            targetL = (stallL < 0) ? int'($urandom_range(0, 3)) : stallL;
         end
      end
   end

   // Right slave model, same behaviour as the left one.
   initial begin : slaveR
      ifR.waitrequest = 1'b0;
      cntR = 0;
      targetR = 0;
      forever begin
         @(posedge clk); #1;
         if (ifR.write) begin
            if (cntR < targetR) begin ifR.waitrequest = 1'b1; cntR++; end
            else ifR.waitrequest = 1'b0;
         end else begin
            ifR.waitrequest = 1'b0;
            cntR = 0;
            targetR = (stallR < 0) ? int'($urandom_range(0, 3)) : stallR;
         end
      end
   end

   task automatic cpuWrite(input logic [1:0] addr, input logic [15:0] data, input logic [1:0] be, input bit expectTxn);
      @(posedge clk); #1;
      s1Address = addr; s1Write = 1'b1; s1Writedata = data; s1Byteenable = be;
      case (addr)
         2'd0: if (be[0]) mCtrl = data[2:0];
         2'd1: begin
            if (be[0]) mValue[7:0] = data[7:0];
            if (be[1]) mValue[15:8] = data[15:8];
         end
         2'd2: begin
            if (be[0]) mPeriod[7:0] = data[7:0];
            if (be[1]) mPeriod[15:8] = data[15:8];
         end
         default: ;
      endcase
      if (expectTxn) pushTxn(mValue, mCtrl[2]);
      @(posedge clk); #1;
      s1Write = 1'b0;
   endtask

   task automatic cpuRead(input logic [1:0] addr, output logic [15:0] data);
      @(posedge clk); #1;
      s1Address = addr; s1Read = 1'b1;
      @(posedge clk); #1;
      s1Read = 1'b0;
      data = s1Readdata;
   endtask

   task automatic waitEmpty(input string name, input int budget);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin @(posedge clk); n++; end
      if (expQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s timeout actual=%0d pending required=0", name, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic waitWrite(input string name, input bit side);
      int n;
      n = 0;
      while (!(side ? ifR.write : ifL.write) && n < 100) begin @(posedge clk); #1; n++; end
      checkOutput(name, 32'(side ? ifR.write : ifL.write), 32'd1);
   endtask

   // Run the counter with the given mode bits for n steps, then stop it.
   task automatic runSteps(input string name, input logic [2:0] mode, input int n);
      logic [15:0] rd;
      cpuWrite(2'd0, {13'd0, mode | 3'b001}, 2'b01, 1'b1);
      for (int i = 0; i < n; i++) begin
         mValue = modelStep(mValue, mCtrl[1], mCtrl[2]);
         pushTxn(mValue, mCtrl[2]);
      end
      waitEmpty(name, 40 * n + 60);
      cpuWrite(2'd0, {13'd0, mode}, 2'b01, 1'b1);
      waitEmpty(name, 60);
      cpuRead(2'd1, rd);
      checkOutput(name, 32'(rd), 32'(mValue));
   endtask

   task automatic applyStimulus();
      logic [15:0] rd;
      int kind;
      // Reset state and the blank push that follows reset release.
      resetN = 1'b0; s1Address = '0; s1Read = 1'b0; s1Write = 1'b0;
      s1Writedata = '0; s1Byteenable = '0; stallL = 0; stallR = 0;
      mValue = '0; mCtrl = '0; mPeriod = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_readdata", 32'(s1Readdata), 32'd0);
      checkOutput("reset_l_write", 32'(ifL.write), 32'd0);
      checkOutput("reset_r_write", 32'(ifR.write), 32'd0);
      checkOutput("reset_l_wdata", 32'(ifL.writedata), 32'd0);
      checkOutput("reset_r_addr_be", 32'({ifR.address, ifR.byteenable}), 32'h3);
      pushTxn(16'h0000, 1'b0);
      checkOutput("blank_word", 32'(expQ[0][15:0]), 32'h4040);
      resetN = 1'b1;
      waitEmpty("post_reset_push", 60);
      cpuRead(2'd3, rd);
      checkOutput("status_idle", 32'(rd), 32'd0);

      // Hex value with a stalled left write.
      stallL = 5;
      cpuWrite(2'd1, 16'h12AB, 2'b11, 1'b1);
      waitEmpty("hex_stall", 80);
      stallL = 0;

      // BCD up across the 9999 wrap.
      cpuWrite(2'd2, 16'd2, 2'b11, 1'b0);
      cpuWrite(2'd0, 16'd4, 2'b01, 1'b1);
      cpuWrite(2'd1, 16'h9998, 2'b11, 1'b1);
      waitEmpty("bcd_setup", 60);
      runSteps("bcd_up", 3'b100, 2);

      // BCD down from 0000, hex down from 0000, hex up across FFFF.
      cpuWrite(2'd0, 16'd6, 2'b01, 1'b1);
      cpuWrite(2'd1, 16'h0000, 2'b11, 1'b1);
      waitEmpty("bcd_down_setup", 60);
      runSteps("bcd_down", 3'b110, 1);
      cpuWrite(2'd0, 16'd2, 2'b01, 1'b1);
      cpuWrite(2'd1, 16'h0000, 2'b11, 1'b1);
      waitEmpty("hex_down_setup", 60);
      runSteps("hex_down", 3'b010, 1);
      runSteps("hex_up", 3'b000, 2);

      // BCD step from a value holding non-decimal nibbles.
      cpuWrite(2'd0, 16'd4, 2'b01, 1'b1);
      cpuWrite(2'd1, 16'h1A9F, 2'b11, 1'b1);
      waitEmpty("clamp_setup", 60);
      runSteps("bcd_clamp", 3'b100, 1);

      // Two VALUE writes during a stalled transaction coalesce into one.
      stallL = 8;
      cpuWrite(2'd1, 16'h0123, 2'b11, 1'b1);
      waitWrite("coalesce_l_write", 1'b0);
      cpuWrite(2'd1, 16'h4567, 2'b11, 1'b0);
      cpuWrite(2'd1, 16'h89AB, 2'b11, 1'b1);
      waitEmpty("coalesce", 120);
      stallL = -1;
      stallR = -1;
      repeat (15) @(posedge clk);
      checkOutput("no_extra_txn", 32'(expQ.size()), 32'd0);
      cpuRead(2'd3, rd);
      checkOutput("status_after_coalesce", 32'(rd), 32'd0);

      // Random register traffic with random slave stalls.
      for (int i = 0; i < 24; i++) begin
         kind = int'($urandom_range(0, 2));
         if (kind == 0) begin
            cpuWrite(2'd0, 16'($urandom) & 16'hFFFE, 2'($urandom_range(1, 3)), 1'b1);
            waitEmpty("rand_ctrl", 80);
            cpuRead(2'd0, rd);
            checkOutput("rand_ctrl_read", 32'(rd), 32'(mCtrl));
         end else if (kind == 1) begin
            cpuWrite(2'd1, 16'($urandom), 2'($urandom_range(1, 3)), 1'b1);
            waitEmpty("rand_value", 80);
            cpuRead(2'd1, rd);
            checkOutput("rand_value_read", 32'(rd), 32'(mValue));
         end else begin
            cpuWrite(2'd2, 16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
            cpuRead(2'd2, rd);
            checkOutput("rand_period_read", 32'(rd), 32'(mPeriod));
         end
      end

      // Reset while the right write is stalled.
      stallR = 20;
      cpuWrite(2'd1, 16'hBEEF, 2'b11, 1'b1);
      waitWrite("reset_wr_r_seen", 1'b1);
      resetN = 1'b0;
      expQ.delete();
      mValue = '0; mCtrl = '0; mPeriod = '0;
      pushTxn(16'h0000, 1'b0);
      stallR = -1;
      @(posedge clk); #1;
      resetN = 1'b1;
      checkOutput("reset_drops_r_write", 32'(ifR.write), 32'd0);
      checkOutput("reset_l_write_low", 32'(ifL.write), 32'd0);
      checkOutput("reset_r_wdata", 32'(ifR.writedata), 32'd0);
      waitEmpty("reset_repush", 80);
      cpuRead(2'd0, rd);
      checkOutput("reset_ctrl", 32'(rd), 32'd0);
      cpuRead(2'd1, rd);
      checkOutput("reset_value", 32'(rd), 32'd0);
      cpuRead(2'd2, rd);
      checkOutput("reset_period", 32'(rd), 32'd0);
      cpuRead(2'd3, rd);
      checkOutput("reset_status", 32'(rd), 32'd0);
      repeat (10) @(posedge clk);
      checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
